// File: rtl/matrix_pkg.sv
// Shared constants, FSM state type and bus slice helpers for the 4x4 matrix units.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_pkg;

    localparam int ELEM_W = 16;
    localparam int DIM    = 4;
    localparam int ROW_W  = DIM * ELEM_W;
    localparam int BUS_W  = DIM * DIM * ELEM_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } as_state_t;

    // Bit offset of element [r][c] on the module bus.
    function automatic int elem_lsb(input int r, input int c);
        return (r * DIM + c) * ELEM_W;
    endfunction

    // Bit offset of row r on the module bus.
    function automatic int row_lsb(input int r);
        return r * ROW_W;
    endfunction

endpackage

// File: rtl/matrix_add_sub_if.sv
// Engine <-> add/sub unit bus: operand/command inputs and result/done outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the unit ignores commands while computing.
interface matrix_add_sub_if;
    import matrix_pkg::*;

    logic [BUS_W-1:0] dataIn;
    logic             asEN;
    logic             asRW;
    logic             matDecide;
    logic             add1sub0;
    logic [BUS_W-1:0] dataOut;
    logic             asFleg;

    modport master (
        output dataIn, asEN, asRW, matDecide, add1sub0,
        input  dataOut, asFleg
    );

    modport slave (
        input  dataIn, asEN, asRW, matDecide, add1sub0,
        output dataOut, asFleg
    );
endinterface

// File: rtl/matrix_add_sub_as_row_alu.sv
// One matrix row of add/sub: DIM parallel signed lanes. Build option MATADD_SATURATE_EN clamps instead of wrapping.
// Latency: combinational.
// Backpressure: none.
module as_row_alu
    import matrix_pkg::*;
(
    input  logic [ROW_W-1:0] row_a_i,
    input  logic [ROW_W-1:0] row_b_i,
    input  logic             add_i,
    output logic [ROW_W-1:0] row_o
);

    for (genvar l = 0; l < DIM; l++) begin : g_lane
        logic [ELEM_W-1:0] a;
        logic [ELEM_W-1:0] b;

        assign a = row_a_i[elem_lsb(0, l) +: ELEM_W];
        assign b = row_b_i[elem_lsb(0, l) +: ELEM_W];

`ifdef MATADD_SATURATE_EN
        // One extra sign bit exposes overflow: the top two bits differ only when the true result left range.
        logic [ELEM_W:0] s;
        assign s = add_i ? ({a[ELEM_W-1], a} + {b[ELEM_W-1], b})
                         : ({a[ELEM_W-1], a} - {b[ELEM_W-1], b});
        assign row_o[elem_lsb(0, l) +: ELEM_W] =
            (s[ELEM_W] != s[ELEM_W-1]) ?
                (s[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}}) :
                s[ELEM_W-1:0];
`else
        assign row_o[elem_lsb(0, l) +: ELEM_W] = add_i ? (a + b) : (a - b);
`endif
    end

endmodule

// File: rtl/matrix_add_sub.sv
// 4x4 matrix A+B / A-B unit: loads two operands, computes one row per cycle, flags done. Option: MATADD_SATURATE_EN.
// Latency: start at edge N, rows written at N+1..N+4, asFleg high after N+4.
// Backpressure: none; commands arriving during COMPUTE are dropped.
module matrix_add_sub
    import matrix_pkg::*;
(
    input  logic            clk,
    input  logic            RESET,
    matrix_add_sub_if.slave bus
);

    as_state_t        state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [BUS_W-1:0] opa_q, opa_d;
    logic [BUS_W-1:0] opb_q, opb_d;
    logic [BUS_W-1:0] dout_q, dout_d;
    logic             flag_q, flag_d;
    logic             add_q, add_d;
    logic [ROW_W-1:0] alu_res;

    as_row_alu u_alu (
        .row_a_i (opa_q[row_lsb(int'(row_q)) +: ROW_W]),
        .row_b_i (opb_q[row_lsb(int'(row_q)) +: ROW_W]),
        .add_i   (add_q),
        .row_o   (alu_res)
    );

    // State and datapath registers; reset wins over any command or pass in flight.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= IDLE;
            row_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            dout_q  <= '0;
            flag_q  <= 1'b0;
            add_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            dout_q  <= dout_d;
            flag_q  <= flag_d;
            add_q   <= add_d;
        end
    end

    // Next state: commands accepted only in IDLE/DONE; COMPUTE walks the rows and ignores the bus.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        dout_d  = dout_q;
        flag_d  = flag_q;
        add_d   = add_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.asEN) begin
                    flag_d = 1'b0;
                    if (bus.asRW) begin
                        add_d   = bus.add1sub0;
                        row_d   = '0;
                        state_d = COMPUTE;
                    end else begin
                        if (bus.matDecide) opb_d = bus.dataIn;
                        else               opa_d = bus.dataIn;
                        state_d = IDLE;
                    end
                end
            end
            COMPUTE: begin
                // Only the current row changes; later rows keep the previous result until reached.
                dout_d[row_lsb(int'(row_q)) +: ROW_W] = alu_res;
                row_d = row_q + 2'd1;
                if (row_q == 2'(DIM - 1)) begin
                    state_d = DONE;
                    flag_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dataOut = dout_q;
    assign bus.asFleg  = flag_q;

endmodule
